program_loader: RTL
===================

# program_loader

Boot-time instruction loader that sits directly upstream of the single-cycle RISC-V core. It accepts a stream of 32-bit instruction words over a valid/ready port and writes them into the core's instruction memory at consecutive word addresses. It holds the core in reset for the whole load, presents the program's start address on `initial_address`, and releases the core's reset a fixed number of cycles after the last word is written.

## Interface
- `DEPTH_WORDS`, 256: instruction-memory capacity in 32-bit words; must be at least 2.
- `RESET_HOLD`, 4: number of cycles the core reset stays asserted after the final write; must be at least 1.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset of this block.
- `load_start`  in  1  one-cycle pulse that starts a load; honoured only in IDLE, RUN or ERROR.
- `base_addr`  in  32  byte address of the first word; latched on an honoured `load_start`; bits [1:0] are forced to 0.
- `ld_valid`  in  1  a stream word is present.
- `ld_data`  in  32  instruction word.
- `ld_last`  in  1  marks the final word; qualified by `ld_valid`.
- `ld_ready`  out  1  the loader accepts a word this cycle.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  32  byte address of the write.
- `imem_wdata`  out  32  data for the write.
- `core_reset`  out  1  drives the core's `reset` input.
- `initial_address`  out  32  drives the core's `initial_address` input.
- `word_count`  out  $clog2(DEPTH_WORDS)+1  number of words accepted in the current or last load.
- `busy`  out  1  high in LOAD and HOLD.
- `done`  out  1  high in RUN.
- `overflow_err`  out  1  high in ERROR.

## Operation
- **States:** IDLE, LOAD, HOLD, RUN, ERROR.
- **Reset values:** state IDLE; `core_reset`=1; every other output is 0, including `initial_address`, `imem_addr` and `word_count`.
- **IDLE:** `core_reset`=1.
  - On `load_start`: go to LOAD.
  - Set the write pointer and `initial_address` to `base_addr & ~3`.
  - Clear `word_count`.
- **LOAD:** `ld_ready`=1 and `core_reset`=1. A handshake is `ld_valid && ld_ready`. On each handshake:
  - On the next cycle: `imem_we`=1, `imem_addr`=pointer, `imem_wdata`=`ld_data`.
  - pointer += 4, wrapping modulo 2^32.
  - `word_count` += 1.
- **LOAD exit:**
  - `ld_last`=1 on a handshake: go to HOLD with the hold counter set to `RESET_HOLD`.
  - A handshake that makes `word_count` equal `DEPTH_WORDS` while `ld_last`=0: that word is still written, then go to ERROR.
  - If `ld_last`=1 and the count reaches `DEPTH_WORDS` on the same handshake, `ld_last` wins and the block goes to HOLD.
- **HOLD:** `core_reset`=1. The hold counter decrements every cycle; when it reaches 0, go to RUN.
- **RUN:** `core_reset`=0 and `done`=1. An honoured `load_start` re-enters LOAD, re-latches `base_addr` and clears `word_count`. `core_reset` returns to 1 on the cycle the block enters LOAD.
- **ERROR:** `core_reset`=1, `overflow_err`=1, `ld_ready`=0. Exit only through `load_start` (to LOAD, which clears `overflow_err`) or through `reset`.
- `load_start` in LOAD or HOLD is ignored.
- Outside the write cycle, `imem_we`=0. `imem_addr` and `imem_wdata` hold their last values.
- `initial_address` is stable from its latch until the next honoured `load_start`.

## Timing
- `ld_ready` is decoded from the registered state only; there is no combinational path from `ld_valid`.
- Write latency is 1 cycle: a handshake in cycle T gives `imem_we` in T+1.
- Full throughput: one word per cycle while `ld_valid` stays high.
- Let the last handshake occur in cycle T:
  - state is HOLD from T+1;
  - `core_reset` falls and `done` rises in cycle T+1+`RESET_HOLD`;
  - the final memory write (T+1) therefore always completes before reset is released.
- An honoured `load_start` in cycle S: state is LOAD and `ld_ready`=1 in S+1.
- A `reset` asserted in any cycle, including mid-load or mid-hold, returns every output to its reset value on the next edge. Any partially loaded words stay in memory but are not executed, because `core_reset`=1.

## Test plan
- **Basic load:** reset, then `load_start` with `base_addr`=0x100, then 3 back-to-back words 0x00500093, 0x00A00113, 0x002081B3 (last on the third), with `RESET_HOLD`=4.
  - Writes go to 0x100, 0x104 and 0x108 with those data values.
  - `initial_address`=0x100 and `word_count`=3.
  - `core_reset` falls exactly 5 cycles after the last handshake; `done`=1.
- **Stalls:** drop `ld_valid` for 2 cycles between each word. Writes occur only the cycle after each handshake, with no duplicate or skipped addresses.
- **Unaligned base:** `base_addr`=0x103. The first write goes to 0x100 and `initial_address`=0x100.
- **Overflow:** with `DEPTH_WORDS`=4, send 4 words with `ld_last`=0.
  - All 4 are written; then `overflow_err`=1, `ld_ready`=0, `core_reset` stays 1.
  - A following `load_start` clears the error.
- **Reload:** `load_start` in RUN with `base_addr`=0x200. `core_reset` goes to 1 in the next cycle; after the second load, `initial_address`=0x200.
- **Reset mid-load:** assert `reset` after 2 of 5 words. The next cycle shows the IDLE reset values, and `load_start` pulses during HOLD are ignored.

Source files
------------

// File: rtl/program_loader_if.sv
// Boot loader bus: instruction stream in (valid/ready/last) plus the instruction-memory write port.
// The slave modport is the loader's own view; master is the host/memory side.
interface program_loader_if;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time instruction loader: streams words into instruction memory, holds the core in
// reset during the load and releases it RESET_HOLD cycles after the final write.
//
// state | meaning
// IDLE  | after reset, core held in reset, waiting for load_start
// LOAD  | accepting stream words, one memory write per handshake
// HOLD  | final word written, counting down before releasing core reset
// RUN   | core running, a new load_start reloads
// ERROR | memory filled without ld_last, core held in reset
module program_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int RESET_HOLD  = 4,
  localparam int CW = $clog2(DEPTH_WORDS) + 1,
  localparam int HW = $clog2(RESET_HOLD + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [31:0]           base_addr,
  program_loader_if.slave       ld,
  output logic                  core_reset,
  output logic [31:0]           initial_address,
  output logic [CW-1:0]         word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HOLD  = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   ptr;
  logic [HW-1:0] hold_cnt;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          hs;
  logic          start_ok;
  logic          count_full;

  assign hs         = ld.ld_valid && (state == S_LOAD);
  assign start_ok   = load_start &&
                      ((state == S_IDLE) || (state == S_RUN) || (state == S_ERROR));
  assign count_full = (word_count + CW'(1)) == CW'(DEPTH_WORDS);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_RUN, S_ERROR: if (load_start) state_nxt = S_LOAD;
      S_LOAD: begin
        // ld_last takes priority over the capacity check on the same word
        if (hs && ld.ld_last)  state_nxt = S_HOLD;
        else if (hs && count_full) state_nxt = S_ERROR;
      end
      S_HOLD: if (hold_cnt == HW'(1)) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr             <= '0;
      initial_address <= '0;
      word_count      <= '0;
      hold_cnt        <= '0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
    end else begin
      we_q <= 1'b0;
      if (start_ok) begin
        ptr             <= base_addr & 32'hFFFF_FFFC;
        initial_address <= base_addr & 32'hFFFF_FFFC;
        word_count      <= '0;
      end
      if (hs) begin
        we_q       <= 1'b1;
        addr_q     <= ptr;
        wdata_q    <= ld.ld_data;
        ptr        <= ptr + 32'd4;
        word_count <= word_count + CW'(1);
      end
      if (hs && ld.ld_last)       hold_cnt <= HW'(RESET_HOLD);
      else if (state == S_HOLD)   hold_cnt <= hold_cnt - HW'(1);
    end
  end

  assign ld.ld_ready   = (state == S_LOAD);
  assign ld.imem_we    = we_q;
  assign ld.imem_addr  = addr_q;
  assign ld.imem_wdata = wdata_q;

  assign core_reset   = (state != S_RUN);
  assign busy         = (state == S_LOAD) || (state == S_HOLD);
  assign done         = (state == S_RUN);
  assign overflow_err = (state == S_ERROR);

endmodule
